// File: rtl/channel_merger2.sv
// channel_merger2: two-into-one valid/ready stream merger.
// Arbitrates two input streams into a 2-entry buffer and emits one
// stream tagged with its source channel.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   in_data_1/in_valid_1/in_ready_1  channel-0 input stream
//   in_data_2/in_valid_2/in_ready_2  channel-1 input stream
//   out_data/out_channel/out_valid/out_ready  merged output stream
// MODE 0 = round-robin, MODE 1 = strict alternation 0,1,0,...
`timescale 1ns/1ps
module channel_merger2 #(
   parameter int width = 32,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [width-1:0] in_data_1,
   input  logic             in_valid_1,
   output logic             in_ready_1,
   input  logic [width-1:0] in_data_2,
   input  logic             in_valid_2,
   output logic             in_ready_2,
   output logic [width-1:0] out_data,
   output logic             out_channel,
   output logic             out_valid,
   input  logic             out_ready
);

   // r_ptr: MODE 0 = channel granted last (reset to 1 so channel 0
   // wins first); MODE 1 = channel expected next (reset to 0).
   localparam logic PTR_RST = (MODE == 0);

   logic [1:0]       r_cnt;
   logic [width-1:0] r_hd_data;
   logic             r_hd_ch;
   logic [width-1:0] r_sk_data;
   logic             r_sk_ch;
   logic             r_ptr;

   logic             w_space;
   logic             w_g1;
   logic             w_g2;
   logic             w_acc1;
   logic             w_acc2;
   logic             w_push;
   logic             w_pop;
   logic [width-1:0] w_ndata;

   // Space comes from the registered count only, so acceptance
   // never depends on out_ready in the same cycle.
   assign w_space = (r_cnt != 2'd2);

   always_comb begin
      w_g1 = 1'b0;
      w_g2 = 1'b0;
      if (MODE == 0) begin
         w_g1 = in_valid_1 & (~in_valid_2 | r_ptr);
         w_g2 = in_valid_2 & (~in_valid_1 | ~r_ptr);
      end else begin
         w_g1 = ~r_ptr;
         w_g2 = r_ptr;
      end
   end

   // Readies are forced low while reset is held.
   assign in_ready_1 = w_g1 & w_space & reset_n;
   assign in_ready_2 = w_g2 & w_space & reset_n;

   assign w_acc1  = in_ready_1 & in_valid_1;
   assign w_acc2  = in_ready_2 & in_valid_2;
   assign w_push  = w_acc1 | w_acc2;
   assign w_pop   = out_valid & out_ready;
   assign w_ndata = w_acc2 ? in_data_2 : in_data_1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= 2'd0;
         r_hd_data <= '0;
         r_hd_ch   <= 1'b0;
         r_sk_data <= '0;
         r_sk_ch   <= 1'b0;
         r_ptr     <= PTR_RST;
      end else begin
         if (w_push) begin
            r_ptr <= (MODE == 0) ? w_acc2 : w_acc1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd0) begin
               r_hd_data <= w_ndata;
               r_hd_ch   <= w_acc2;
            end else begin
               r_sk_data <= w_ndata;
               r_sk_ch   <= w_acc2;
            end
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 2'd1;
            // With one entry left the head just holds (don't-care).
            if (r_cnt == 2'd2) begin
               r_hd_data <= r_sk_data;
               r_hd_ch   <= r_sk_ch;
            end
         end else if (w_push && w_pop) begin
            // Only reachable with exactly one entry: replace the head.
            r_hd_data <= w_ndata;
            r_hd_ch   <= w_acc2;
         end
      end
   end

   assign out_data    = r_hd_data;
   assign out_channel = r_hd_ch;
   assign out_valid   = (r_cnt != 2'd0);

endmodule

// File: tb/tb_channel_merger2.sv
// tb_channel_merger2: directed bench for channel_merger2.
// u_rr runs MODE 0, u_alt runs MODE 1, sharing clock and reset.
`timescale 1ns/1ps
module tb_channel_merger2;

   logic        clk;
   logic        reset_n;

   logic [31:0] a_d1, a_d2, a_od;
   logic        a_v1, a_v2, a_r1, a_r2, a_oc, a_ov, a_ordy;
   logic [31:0] b_d1, b_d2, b_od;
   logic        b_v1, b_v2, b_r1, b_r2, b_oc, b_ov, b_ordy;

   logic [31:0] ab1, ab2, ai1, ai2;
   logic [31:0] bb1, bb2, bi1, bi2;
   int          acnt;
   int          n_vec;
   int          n_err;

   assign a_d1 = ab1 + ai1;
   assign a_d2 = ab2 + ai2;
   assign b_d1 = bb1 + bi1;
   assign b_d2 = bb2 + bi2;

   channel_merger2 #(.width(32), .MODE(0)) u_rr (
      .clk(clk), .reset_n(reset_n),
      .in_data_1(a_d1), .in_valid_1(a_v1), .in_ready_1(a_r1),
      .in_data_2(a_d2), .in_valid_2(a_v2), .in_ready_2(a_r2),
      .out_data(a_od), .out_channel(a_oc), .out_valid(a_ov),
      .out_ready(a_ordy)
   );

   channel_merger2 #(.width(32), .MODE(1)) u_alt (
      .clk(clk), .reset_n(reset_n),
      .in_data_1(b_d1), .in_valid_1(b_v1), .in_ready_1(b_r1),
      .in_data_2(b_d2), .in_valid_2(b_v2), .in_ready_2(b_r2),
      .out_data(b_od), .out_channel(b_oc), .out_valid(b_ov),
      .out_ready(b_ordy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes, take the edge, advance the
   // per-channel word index for every accepted word.
   task automatic tick();
      logic a1, a2, b1, b2;
      #1;
      a1 = a_r1 & a_v1;
      a2 = a_r2 & a_v2;
      b1 = b_r1 & b_v1;
      b2 = b_r2 & b_v2;
      chk("rr_onehot", {31'd0, a_r1 & a_r2}, 32'd0);
      chk("alt_onehot", {31'd0, b_r1 & b_r2}, 32'd0);
      @(posedge clk);
      #1;
      if (a1) ai1 = ai1 + 32'd1;
      if (a2) ai2 = ai2 + 32'd1;
      if (b1) bi1 = bi1 + 32'd1;
      if (b2) bi2 = bi2 + 32'd1;
      acnt = acnt + int'(a1) + int'(a2);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      acnt = 0;
      reset_n = 1'b0;
      ab1 = 32'hA0; ab2 = 32'hB0; ai1 = 0; ai2 = 0;
      bb1 = 32'h11; bb2 = 32'h22; bi1 = 0; bi2 = 0;
      a_v1 = 1'b1; a_v2 = 1'b1; a_ordy = 1'b1;
      b_v1 = 1'b1; b_v2 = 1'b1; b_ordy = 1'b1;

      // Reset with inputs valid
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ov", {31'd0, a_ov}, 32'd0);
      chk("rst_r1", {31'd0, a_r1}, 32'd0);
      chk("rst_r2", {31'd0, a_r2}, 32'd0);
      chk("rst_od", a_od, 32'd0);
      chk("rst_b_r1", {31'd0, b_r1}, 32'd0);
      chk("rst_b_r2", {31'd0, b_r2}, 32'd0);
      reset_n = 1'b1;
      b_v1 = 1'b0;
      b_v2 = 1'b0;
      #1;
      chk("first_r1", {31'd0, a_r1}, 32'd1);
      chk("first_r2", {31'd0, a_r2}, 32'd0);

      // MODE 0 both valid, streaming
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("rr_ov", {31'd0, a_ov}, 32'd1);
         chk("rr_od", a_od, (k % 2 == 1) ?
             32'hA0 + 32'((k - 1) / 2) : 32'hB0 + 32'((k - 1) / 2));
         chk("rr_oc", {31'd0, a_oc}, (k % 2 == 1) ? 32'd0 : 32'd1);
      end
      a_v1 = 1'b0;
      a_v2 = 1'b0;
      tick();
      chk("rr_empty", {31'd0, a_ov}, 32'd0);
      chk("rr_hold", a_od, 32'hB2);

      // Only ch1 valid
      ab2 = 32'h55; ai2 = 0;
      a_v2 = 1'b1;
      #1;
      chk("solo_r1", {31'd0, a_r1}, 32'd0);
      chk("solo_r2", {31'd0, a_r2}, 32'd1);
      tick();
      a_v2 = 1'b0;
      #1;
      chk("solo_ov", {31'd0, a_ov}, 32'd1);
      chk("solo_od", a_od, 32'h55);
      chk("solo_oc", {31'd0, a_oc}, 32'd1);
      chk("solo_r1b", {31'd0, a_r1}, 32'd0);
      tick();
      chk("solo_empty", {31'd0, a_ov}, 32'd0);

      // Backpressure: exactly two accepted, then drain
      ab1 = 32'hC0; ab2 = 32'hD0; ai1 = 0; ai2 = 0;
      a_ordy = 1'b0;
      a_v1 = 1'b1;
      a_v2 = 1'b1;
      acnt = 0;
      repeat (4) tick();
      chk("bp_cnt", 32'(acnt), 32'd2);
      chk("bp_r1", {31'd0, a_r1}, 32'd0);
      chk("bp_r2", {31'd0, a_r2}, 32'd0);
      chk("bp_od", a_od, 32'hC0);
      chk("bp_oc", {31'd0, a_oc}, 32'd0);
      a_ordy = 1'b1;
      tick();
      chk("dr0_od", a_od, 32'hD0);
      chk("dr0_oc", {31'd0, a_oc}, 32'd1);
      tick();
      chk("dr1_od", a_od, 32'hC1);
      chk("dr1_oc", {31'd0, a_oc}, 32'd0);
      tick();
      chk("dr2_od", a_od, 32'hD1);
      chk("dr2_oc", {31'd0, a_oc}, 32'd1);
      a_v1 = 1'b0;
      a_v2 = 1'b0;
      tick();
      chk("dr_empty", {31'd0, a_ov}, 32'd0);

      // MODE 1: ch1 waits for ch0
      bi1 = 0; bi2 = 0;
      b_v2 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("alt_wait_r2", {31'd0, b_r2}, 32'd0);
         chk("alt_wait_ov", {31'd0, b_ov}, 32'd0);
         tick();
      end
      chk("alt_rbv", {31'd0, b_r1}, 32'd1);
      b_v1 = 1'b1;
      #1;
      chk("alt_r1", {31'd0, b_r1}, 32'd1);
      tick();
      b_v1 = 1'b0;
      #1;
      chk("alt_od0", b_od, 32'h11);
      chk("alt_oc0", {31'd0, b_oc}, 32'd0);
      chk("alt_r2", {31'd0, b_r2}, 32'd1);
      tick();
      #1;
      chk("alt_od1", b_od, 32'h22);
      chk("alt_oc1", {31'd0, b_oc}, 32'd1);
      chk("alt_no2x", {31'd0, b_r2}, 32'd0);
      chk("alt_r1n", {31'd0, b_r1}, 32'd1);
      tick();
      chk("alt_empty", {31'd0, b_ov}, 32'd0);
      b_v2 = 1'b0;

      // Reset with two words buffered
      ab1 = 32'hE0; ab2 = 32'hF0; ai1 = 0; ai2 = 0;
      a_ordy = 1'b0;
      a_v1 = 1'b1;
      a_v2 = 1'b1;
      tick();
      tick();
      chk("full_ov", {31'd0, a_ov}, 32'd1);
      chk("full_od", a_od, 32'hE0);
      reset_n = 1'b0;
      #1;
      chk("arst_ov", {31'd0, a_ov}, 32'd0);
      chk("arst_od", a_od, 32'd0);
      chk("arst_r1", {31'd0, a_r1}, 32'd0);
      chk("arst_r2", {31'd0, a_r2}, 32'd0);
      @(posedge clk);
      #1;
      ai1 = 0;
      ai2 = 0;
      reset_n = 1'b1;
      a_ordy = 1'b1;
      #1;
      chk("rel_ov", {31'd0, a_ov}, 32'd0);
      chk("rel_r1", {31'd0, a_r1}, 32'd1);
      chk("rel_r2", {31'd0, a_r2}, 32'd0);
      tick();
      chk("rel_od0", a_od, 32'hE0);
      chk("rel_oc0", {31'd0, a_oc}, 32'd0);
      tick();
      chk("rel_od1", a_od, 32'hF0);
      chk("rel_oc1", {31'd0, a_oc}, 32'd1);
      a_v1 = 1'b0;
      a_v2 = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
